axi4_memory_slave: RTL and testbench
====================================

# axi4_memory_slave

AXI4 subordinate with an internal word-addressed RAM; the responder end of the AXI4 link driven by `axi4_memory_controller`. It accepts write and read bursts on independent channels, stores/returns data, and reports per-burst status. Serves as the memory model for controller benches and as on-chip scratch RAM in the design.

## Interface
- DATA_WIDTH, 32, data bus width in bits (32 or 64)
- ADDR_WIDTH, 32, byte address width
- MEM_DEPTH, 1024, RAM depth in words (power of two)

Clock: `clk`, one clock. Reset: `reset_n`, asynchronous, active-low.

- clk  input  1  clock, rising edge
- reset_n  input  1  asynchronous active-low reset
- axi_awaddr  input  ADDR_WIDTH  write burst start byte address
- axi_awlen  input  8  beats minus one
- axi_awsize  input  3  bytes-per-beat code
- axi_awburst  input  2  00 FIXED, 01 INCR, 10 WRAP
- axi_awvalid / axi_awready  input / output  1  AW handshake
- axi_wdata  input  DATA_WIDTH  write data
- axi_wlast  input  1  final write beat marker
- axi_wvalid / axi_wready  input / output  1  W handshake
- axi_bresp  output  2  write response
- axi_bvalid / axi_bready  output / input  1  B handshake
- axi_araddr, axi_arlen, axi_arsize, axi_arburst  input  ADDR_WIDTH, 8, 3, 2  read burst request
- axi_arvalid / axi_arready  input / output  1  AR handshake
- axi_rdata  output  DATA_WIDTH  read data (registered)
- axi_rresp  output  2  per-beat read response
- axi_rlast  output  1  final read beat marker
- axi_rvalid / axi_rready  output / input  1  R handshake

## Operation
- Word index = byte address >> log2(DATA_WIDTH/8); an address is valid when its word index < MEM_DEPTH, otherwise out-of-range.
- Write FSM: W_IDLE (awready=1) -> W_DATA on AW handshake (latch addr, len, burst, size) -> W_RESP after beat awlen+1 accepted -> W_IDLE on B handshake.
- W_DATA: wready=1; each W handshake writes the word at the current address if the beat is valid; INCR adds DATA_WIDTH/8 per beat, FIXED holds the address.
- Burst error (SLVERR 2'b10): burst=WRAP or 2'b11, or size != log2(DATA_WIDTH/8); all writes of that burst suppressed, reads return 0. Unsupported burst does not change beat count.
- wlast mismatch (asserted before beat awlen+1, or absent on it): bresp=SLVERR; beats keep writing; burst ends on beat count, not on wlast.
- Any out-of-range beat: that beat suppressed/returns 0; response DECERR 2'b11. Precedence for bresp: DECERR > SLVERR > OKAY 2'b00.
- Read FSM: R_IDLE (arready=1) -> R_DATA on AR handshake -> R_IDLE on handshake of beat arlen+1. rlast=1 only on that beat. rresp per beat: DECERR if beat out-of-range, else SLVERR if burst error, else OKAY.
- Channels are independent; a read and a write may be active concurrently. Same-word read and write in one cycle: read returns the old data.
- RAM contents are not reset.

## Timing
- Reset values: awready, wready, bvalid, arready, rvalid, rlast = 0; bresp, rresp = 2'b00; rdata = 0. awready/arready rise on the first rising edge after reset release.
- Reset asserted mid-burst: both FSMs return to IDLE immediately, outputs take reset values, burst abandoned; words already written remain.
- Write: AW handshake edge N -> wready=1 from N+1; one beat per cycle; last beat edge M -> bvalid=1 from M+1, held with bresp stable until bready; B handshake edge P -> awready=1 from P+1.
- Read: AR handshake edge N -> rvalid=1 with beat 0 from N+1; beat k+1 valid the cycle after beat k handshake (full throughput). While rvalid=1 and rready=0, rdata/rresp/rlast are held stable.
- Last read handshake edge M -> rvalid=0, arready=1 from M+1.
- awready/arready never asserted outside IDLE; at most one outstanding burst per direction.

## Test plan
- INCR write awaddr=0x10, awlen=3, wdata 0xA0..0xA3 -> bresp=00 one cycle after last beat; words 4..7 hold 0xA0..0xA3.
- INCR read araddr=0x10, arlen=3, rready=1 -> rdata 0xA0,0xA1,0xA2,0xA3 on consecutive cycles starting one cycle after AR, rlast only on 0xA3, rresp=00.
- Same read with rready toggling 1,0,0,1,... -> each rdata held stable until accepted; sequence unchanged.
- FIXED write awaddr=0x20, awlen=2, data 1,2,3 -> word 8 = 3, words 9-10 unchanged; bresp=00.
- awaddr=MEM_DEPTH*4, awlen=0 -> bresp=11, RAM unchanged; same araddr read -> rdata=0, rresp=11, rlast=1. WRAP write -> bresp=10; wlast on beat 1 of awlen=3 -> bresp=10 after 4 beats.
- reset_n low during beat 2 of a 4-beat write -> all outputs at reset values; words 0-1 of burst written; new burst accepted normally after release.

Source files
------------

// File: rtl/axi4_memory_slave.sv
// AXI4 subordinate backed by a word-addressed RAM.
// Independent write and read burst engines with per-burst status.
module axi4_memory_slave #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int MEM_DEPTH  = 1024
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [ADDR_WIDTH-1:0] axi_awaddr,
    input  logic [7:0]            axi_awlen,
    input  logic [2:0]            axi_awsize,
    input  logic [1:0]            axi_awburst,
    input  logic                  axi_awvalid,
    output logic                  axi_awready,
    input  logic [DATA_WIDTH-1:0] axi_wdata,
    input  logic                  axi_wlast,
    input  logic                  axi_wvalid,
    output logic                  axi_wready,
    output logic [1:0]            axi_bresp,
    output logic                  axi_bvalid,
    input  logic                  axi_bready,
    input  logic [ADDR_WIDTH-1:0] axi_araddr,
    input  logic [7:0]            axi_arlen,
    input  logic [2:0]            axi_arsize,
    input  logic [1:0]            axi_arburst,
    input  logic                  axi_arvalid,
    output logic                  axi_arready,
    output logic [DATA_WIDTH-1:0] axi_rdata,
    output logic [1:0]            axi_rresp,
    output logic                  axi_rlast,
    output logic                  axi_rvalid,
    input  logic                  axi_rready
);

    localparam int BYTES = DATA_WIDTH / 8;
    localparam int SHIFT = $clog2(BYTES);
    localparam int IDX_W = $clog2(MEM_DEPTH);
    localparam logic [2:0] SIZE_OK = 3'(SHIFT);
    localparam logic [ADDR_WIDTH-1:0] STEP = ADDR_WIDTH'(BYTES);

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef enum logic [1:0] {W_INIT, W_IDLE, W_DATA, W_RESP} w_state_t;
    typedef enum logic [1:0] {R_INIT, R_IDLE, R_DATA} r_state_t;

    function automatic logic in_range(input logic [ADDR_WIDTH-1:0] a);
        return (a >> (SHIFT + IDX_W)) == '0;
    endfunction

    function automatic logic [IDX_W-1:0] word_idx(
        input logic [ADDR_WIDTH-1:0] a
    );
        return a[SHIFT +: IDX_W];
    endfunction

    function automatic logic burst_err(
        input logic [1:0] burst,
        input logic [2:0] size
    );
        return burst[1] || (size != SIZE_OK);
    endfunction

    logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

    // ---------------- write channel ----------------
    w_state_t              w_state, w_next;
    logic [ADDR_WIDTH-1:0] w_addr;
    logic [7:0]            w_len, w_cnt;
    logic                  w_fixed, w_berr, w_dec, w_slv;
    logic [1:0]            bresp_q;
    logic                  aw_hs, w_hs, b_hs, w_final, w_beat_ok;
    logic                  w_dec_nx, w_slv_nx, mem_we;

    assign aw_hs     = axi_awvalid && axi_awready;
    assign w_hs      = axi_wvalid && axi_wready;
    assign b_hs      = axi_bvalid && axi_bready;
    assign w_final   = (w_cnt == w_len);
    assign w_beat_ok = in_range(w_addr);
    assign w_dec_nx  = w_dec || !w_beat_ok;
    assign w_slv_nx  = w_slv || (axi_wlast != w_final);
    assign mem_we    = w_hs && w_beat_ok && !w_berr;
    assign axi_bresp = bresp_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) w_state <= W_INIT;
        else          w_state <= w_next;
    end

    always_comb begin
        w_next = w_state;
        case (w_state)
            W_INIT:  w_next = W_IDLE;
            W_IDLE:  if (aw_hs) w_next = W_DATA;
            W_DATA:  if (w_hs && w_final) w_next = W_RESP;
            W_RESP:  if (b_hs) w_next = W_IDLE;
            default: w_next = W_INIT;
        endcase
    end

    always_comb begin
        axi_awready = 1'b0;
        axi_wready  = 1'b0;
        axi_bvalid  = 1'b0;
        case (w_state)
            W_IDLE:  axi_awready = 1'b1;
            W_DATA:  axi_wready  = 1'b1;
            W_RESP:  axi_bvalid  = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            w_addr  <= '0;
            w_len   <= '0;
            w_cnt   <= '0;
            w_fixed <= 1'b0;
            w_berr  <= 1'b0;
            w_dec   <= 1'b0;
            w_slv   <= 1'b0;
            bresp_q <= RESP_OKAY;
        end else begin
            if (aw_hs) begin
                w_addr  <= axi_awaddr;
                w_len   <= axi_awlen;
                w_cnt   <= '0;
                w_fixed <= (axi_awburst == 2'b00);
                w_berr  <= burst_err(axi_awburst, axi_awsize);
                w_slv   <= burst_err(axi_awburst, axi_awsize);
                w_dec   <= 1'b0;
            end
            if (w_hs) begin
                w_cnt <= w_cnt + 8'd1;
                w_dec <= w_dec_nx;
                w_slv <= w_slv_nx;
                if (!w_fixed) w_addr <= w_addr + STEP;
                // burst length is set by awlen; wlast only feeds status
                if (w_final)
                    bresp_q <= w_dec_nx ? RESP_DECERR :
                               w_slv_nx ? RESP_SLVERR : RESP_OKAY;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) mem[word_idx(w_addr)] <= axi_wdata;
    end

    // ---------------- read channel ----------------
    r_state_t              r_state, r_next;
    logic [ADDR_WIDTH-1:0] r_addr, ld_addr;
    logic [7:0]            r_len, r_cnt;
    logic                  r_fixed, r_berr;
    logic [DATA_WIDTH-1:0] rdata_q, ld_data;
    logic [1:0]            rresp_q, ld_resp;
    logic                  rlast_q, ld_last, ld_berr, ld_ok;
    logic                  ar_hs, r_hs, r_final, r_load;

    assign ar_hs   = axi_arvalid && axi_arready;
    assign r_hs    = axi_rvalid && axi_rready;
    assign r_final = (r_cnt == r_len);
    assign r_load  = ar_hs || (r_hs && !r_final);

    assign axi_rdata = rdata_q;
    assign axi_rresp = rresp_q;
    assign axi_rlast = rlast_q;

    // next beat is fetched on the accepting edge so R runs at full rate
    always_comb begin
        ld_addr = ar_hs ? axi_araddr :
                  r_fixed ? r_addr : r_addr + STEP;
        ld_berr = ar_hs ? burst_err(axi_arburst, axi_arsize) : r_berr;
        ld_last = ar_hs ? (axi_arlen == 8'd0) : (r_cnt + 8'd1 == r_len);
        ld_ok   = in_range(ld_addr);
        ld_data = (ld_ok && !ld_berr) ? mem[word_idx(ld_addr)] : '0;
        ld_resp = !ld_ok  ? RESP_DECERR :
                  ld_berr ? RESP_SLVERR : RESP_OKAY;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) r_state <= R_INIT;
        else          r_state <= r_next;
    end

    always_comb begin
        r_next = r_state;
        case (r_state)
            R_INIT:  r_next = R_IDLE;
            R_IDLE:  if (ar_hs) r_next = R_DATA;
            R_DATA:  if (r_hs && r_final) r_next = R_IDLE;
            default: r_next = R_INIT;
        endcase
    end

    always_comb begin
        axi_arready = 1'b0;
        axi_rvalid  = 1'b0;
        case (r_state)
            R_IDLE:  axi_arready = 1'b1;
            R_DATA:  axi_rvalid  = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_addr  <= '0;
            r_len   <= '0;
            r_cnt   <= '0;
            r_fixed <= 1'b0;
            r_berr  <= 1'b0;
            rdata_q <= '0;
            rresp_q <= RESP_OKAY;
            rlast_q <= 1'b0;
        end else begin
            if (ar_hs) begin
                r_len   <= axi_arlen;
                r_fixed <= (axi_arburst == 2'b00);
                r_berr  <= ld_berr;
            end
            if (r_load) begin
                r_addr  <= ld_addr;
                r_cnt   <= ar_hs ? 8'd0 : r_cnt + 8'd1;
                rdata_q <= ld_data;
                rresp_q <= ld_resp;
                rlast_q <= ld_last;
            end else if (r_hs) begin
                rlast_q <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_axi4_memory_slave.sv
// Scoreboard bench for axi4_memory_slave: random and directed bursts
// checked against a word-array reference model.
module tb_axi4_memory_slave;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [31:0] axi_awaddr;
    logic [7:0]  axi_awlen;
    logic [2:0]  axi_awsize;
    logic [1:0]  axi_awburst;
    logic        axi_awvalid;
    logic        axi_awready;
    logic [31:0] axi_wdata;
    logic        axi_wlast;
    logic        axi_wvalid;
    logic        axi_wready;
    logic [1:0]  axi_bresp;
    logic        axi_bvalid;
    logic        axi_bready;
    logic [31:0] axi_araddr;
    logic [7:0]  axi_arlen;
    logic [2:0]  axi_arsize;
    logic [1:0]  axi_arburst;
    logic        axi_arvalid;
    logic        axi_arready;
    logic [31:0] axi_rdata;
    logic [1:0]  axi_rresp;
    logic        axi_rlast;
    logic        axi_rvalid;
    logic        axi_rready;

    axi4_memory_slave #(
        .DATA_WIDTH(32), .ADDR_WIDTH(32), .MEM_DEPTH(1024)
    ) dut (
        .clk(clk), .reset_n(reset_n),
        .axi_awaddr(axi_awaddr), .axi_awlen(axi_awlen),
        .axi_awsize(axi_awsize), .axi_awburst(axi_awburst),
        .axi_awvalid(axi_awvalid), .axi_awready(axi_awready),
        .axi_wdata(axi_wdata), .axi_wlast(axi_wlast),
        .axi_wvalid(axi_wvalid), .axi_wready(axi_wready),
        .axi_bresp(axi_bresp), .axi_bvalid(axi_bvalid),
        .axi_bready(axi_bready),
        .axi_araddr(axi_araddr), .axi_arlen(axi_arlen),
        .axi_arsize(axi_arsize), .axi_arburst(axi_arburst),
        .axi_arvalid(axi_arvalid), .axi_arready(axi_arready),
        .axi_rdata(axi_rdata), .axi_rresp(axi_rresp),
        .axi_rlast(axi_rlast), .axi_rvalid(axi_rvalid),
        .axi_rready(axi_rready)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        last;
        logic [1:0]  resp;
        logic [31:0] data;
    } rbeat_t;

    int          checks = 0;
    int          failures = 0;
    logic [31:0] model [1024];
    logic [31:0] wbuf [256];
    logic [1:0]  bq [$];
    rbeat_t      rq [$];
    logic        r_held = 1'b0;
    rbeat_t      held_beat;
    logic [1:0]  b_exp;
    rbeat_t      r_exp;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Monitor: pops expectations whenever a B or R handshake is pending.
    always @(negedge clk) begin
        if (axi_bvalid && axi_bready) begin
            if (bq.size() == 0) begin
                chk("b_unexpected", 64'(axi_bvalid), 64'd0);
            end else begin
                b_exp = bq.pop_front();
                chk("bresp", 64'(axi_bresp), 64'(b_exp));
            end
        end
        if (r_held)
            chk("r_hold", {28'd0, axi_rvalid, axi_rlast, axi_rresp, axi_rdata},
                {28'd0, 1'b1, held_beat});
        if (axi_rvalid && axi_rready) begin
            if (rq.size() == 0) begin
                chk("r_unexpected", 64'(axi_rvalid), 64'd0);
            end else begin
                r_exp = rq.pop_front();
                chk("rbeat", 64'({axi_rlast, axi_rresp, axi_rdata}),
                    64'(r_exp));
            end
        end
        r_held    = axi_rvalid && !axi_rready;
        held_beat = {axi_rlast, axi_rresp, axi_rdata};
    end

    function automatic logic [31:0] beat_addr(input logic [31:0] addr,
                                              input logic [1:0] burst,
                                              input int k);
        return (burst == 2'b00) ? addr : addr + 32'(4 * k);
    endfunction

    task automatic write_burst(input logic [31:0] addr, input int len,
                               input logic [2:0] size, input logic [1:0] burst,
                               input int bad, input bit gaps);
        bit berr, dec, slv;
        logic [31:0] a;
        int n;
        berr = burst[1] || (size != 3'd2);
        dec  = 1'b0;
        slv  = berr || (bad >= 0);
        for (int k = 0; k <= len; k++) begin
            a = beat_addr(addr, burst, k);
            if ((a >> 2) >= 1024) dec = 1'b1;
            else if (!berr) model[a[11:2]] = wbuf[k];
        end
        bq.push_back(dec ? 2'b11 : slv ? 2'b10 : 2'b00);
        @(posedge clk); #1;
        axi_awaddr  = addr;
        axi_awlen   = 8'(len);
        axi_awsize  = size;
        axi_awburst = burst;
        axi_awvalid = 1'b1;
        n = 0;
        forever begin
            @(negedge clk);
            if (axi_awready) break;
            if (++n > 50) begin
                chk("aw_timeout", 64'(axi_awready), 64'd1);
                axi_awvalid = 1'b0;
                return;
            end
            @(posedge clk); #1;
        end
        @(posedge clk); #1;
        axi_awvalid = 1'b0;
        @(negedge clk);
        chk("wready_lat", 64'(axi_wready), 64'd1);
        @(posedge clk); #1;
        for (int k = 0; k <= len; k++) begin
            if (gaps && $urandom_range(0, 3) == 0) begin
                axi_wvalid = 1'b0;
                @(posedge clk); #1;
            end
            axi_wdata  = wbuf[k];
            axi_wlast  = (k == len) ^ (k == bad);
            axi_wvalid = 1'b1;
            n = 0;
            forever begin
                @(negedge clk);
                if (axi_wready) break;
                if (++n > 50) begin
                    chk("w_timeout", 64'(axi_wready), 64'd1);
                    axi_wvalid = 1'b0;
                    return;
                end
                @(posedge clk); #1;
            end
            @(posedge clk); #1;
        end
        axi_wvalid = 1'b0;
        axi_wlast  = 1'b0;
        @(negedge clk);
        chk("bvalid_lat", {axi_bvalid, axi_wready}, 2'b10);
        @(posedge clk); #1;
        n = 0;
        forever begin
            axi_bready = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
            @(negedge clk);
            if (axi_bvalid && axi_bready) break;
            if (++n > 50) begin
                chk("b_timeout", 64'(axi_bvalid), 64'd1);
                axi_bready = 1'b0;
                return;
            end
            @(posedge clk); #1;
        end
        @(posedge clk); #1;
        axi_bready = 1'b0;
        @(negedge clk);
        chk("awready_after_b", {axi_awready, axi_bvalid}, 2'b10);
    endtask

    task automatic read_burst(input logic [31:0] addr, input int len,
                              input logic [2:0] size, input logic [1:0] burst,
                              input int mode);
        bit berr, inr;
        logic [31:0] a;
        rbeat_t e;
        int n, beats;
        berr = burst[1] || (size != 3'd2);
        for (int k = 0; k <= len; k++) begin
            a      = beat_addr(addr, burst, k);
            inr    = (a >> 2) < 1024;
            e.data = (inr && !berr) ? model[a[11:2]] : 32'd0;
            e.resp = !inr ? 2'b11 : berr ? 2'b10 : 2'b00;
            e.last = (k == len);
            rq.push_back(e);
        end
        @(posedge clk); #1;
        axi_araddr  = addr;
        axi_arlen   = 8'(len);
        axi_arsize  = size;
        axi_arburst = burst;
        axi_arvalid = 1'b1;
        n = 0;
        forever begin
            @(negedge clk);
            if (axi_arready) break;
            if (++n > 50) begin
                chk("ar_timeout", 64'(axi_arready), 64'd1);
                axi_arvalid = 1'b0;
                return;
            end
            @(posedge clk); #1;
        end
        @(posedge clk); #1;
        axi_arvalid = 1'b0;
        @(negedge clk);
        chk("rvalid_lat", {axi_rvalid, axi_arready}, 2'b10);
        @(posedge clk); #1;
        beats = 0;
        n = 0;
        while (beats <= len) begin
            case (mode)
                0:       axi_rready = 1'b1;
                1:       axi_rready = (n % 3 == 0);
                default: axi_rready = 1'($urandom_range(0, 1));
            endcase
            @(negedge clk);
            if (axi_rvalid && axi_rready) beats++;
            if (++n > 2000) begin
                chk("r_timeout", 64'(beats), 64'(len + 1));
                break;
            end
            @(posedge clk); #1;
        end
        axi_rready = 1'b0;
        @(negedge clk);
        chk("arready_after_r", {axi_arready, axi_rvalid}, 2'b10);
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_ready_valid"},
            64'({axi_awready, axi_wready, axi_bvalid,
                 axi_arready, axi_rvalid, axi_rlast}), 64'd0);
        chk({tag, "_resp_data"}, 64'({axi_bresp, axi_rresp, axi_rdata}), 64'd0);
    endtask

    initial begin
        #800000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] addr;
        int len;
        reset_n     = 1'b0;
        axi_awaddr  = '0; axi_awlen = '0; axi_awsize = '0; axi_awburst = '0;
        axi_awvalid = 1'b0;
        axi_wdata   = '0; axi_wlast = 1'b0; axi_wvalid = 1'b0;
        axi_bready  = 1'b0;
        axi_araddr  = '0; axi_arlen = '0; axi_arsize = '0; axi_arburst = '0;
        axi_arvalid = 1'b0;
        axi_rready  = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_vals("reset");
        reset_n = 1'b1;
        @(negedge clk);
        chk("ready_before_edge", {axi_awready, axi_arready}, 2'b00);
        @(posedge clk); #1;
        @(negedge clk);
        chk("ready_after_edge", {axi_awready, axi_arready}, 2'b11);

        for (int b = 0; b < 4; b++) begin
            for (int k = 0; k < 256; k++) wbuf[k] = $urandom;
            write_burst(32'(b * 1024), 255, 3'd2, 2'b01, -1, 1'b0);
        end

        for (int k = 0; k < 4; k++) wbuf[k] = 32'hA0 + 32'(k);
        write_burst(32'h10, 3, 3'd2, 2'b01, -1, 1'b0);
        read_burst(32'h10, 3, 3'd2, 2'b01, 0);
        read_burst(32'h10, 3, 3'd2, 2'b01, 1);

        for (int k = 0; k < 3; k++) wbuf[k] = 32'(k + 1);
        write_burst(32'h20, 2, 3'd2, 2'b00, -1, 1'b0);
        read_burst(32'h20, 2, 3'd2, 2'b01, 2);

        wbuf[0] = $urandom;
        write_burst(32'd4096, 0, 3'd2, 2'b01, -1, 1'b0);
        read_burst(32'd4096, 0, 3'd2, 2'b01, 0);

        for (int k = 0; k < 4; k++) wbuf[k] = $urandom;
        write_burst(32'h30, 3, 3'd2, 2'b10, -1, 1'b0);
        read_burst(32'h30, 3, 3'd2, 2'b01, 0);
        read_burst(32'h30, 1, 3'd2, 2'b10, 0);

        for (int k = 0; k < 4; k++) wbuf[k] = $urandom;
        write_burst(32'h50, 3, 3'd2, 2'b01, 1, 1'b0);
        read_burst(32'h50, 3, 3'd2, 2'b01, 0);

        for (int k = 0; k < 2; k++) wbuf[k] = $urandom;
        write_burst(32'h60, 1, 3'd1, 2'b01, -1, 1'b0);
        read_burst(32'h60, 1, 3'd2, 2'b01, 2);

        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 3) == 0)
                addr = 32'($urandom_range(1015, 1030)) << 2;
            else
                addr = 32'($urandom_range(0, 1039)) << 2;
            len = $urandom_range(0, 15);
            if ($urandom_range(0, 1) == 0) begin
                for (int k = 0; k <= len; k++) wbuf[k] = $urandom;
                write_burst(addr, len,
                            ($urandom_range(0, 9) == 0) ? 3'd1 : 3'd2,
                            2'($urandom_range(0, 1)),
                            ($urandom_range(0, 5) == 0) ?
                                $urandom_range(0, len) : -1,
                            1'b1);
            end else begin
                read_burst(addr, len,
                           ($urandom_range(0, 9) == 0) ? 3'd1 : 3'd2,
                           2'($urandom_range(0, 1)), 2);
            end
        end

        for (int k = 0; k < 8; k++) wbuf[k] = $urandom;
        fork
            write_burst(32'h100, 7, 3'd2, 2'b01, -1, 1'b1);
            read_burst(32'h200, 7, 3'd2, 2'b01, 2);
        join
        read_burst(32'h100, 7, 3'd2, 2'b01, 0);

        // reset in the middle of a 4-beat write to words 16..19
        for (int k = 0; k < 4; k++) wbuf[k] = $urandom;
        @(posedge clk); #1;
        axi_awaddr = 32'h40; axi_awlen = 8'd3;
        axi_awsize = 3'd2;   axi_awburst = 2'b01;
        axi_awvalid = 1'b1;
        @(negedge clk);
        chk("rst_aw_ready", 64'(axi_awready), 64'd1);
        @(posedge clk); #1;
        axi_awvalid = 1'b0;
        for (int k = 0; k < 2; k++) begin
            axi_wdata = wbuf[k]; axi_wlast = 1'b0; axi_wvalid = 1'b1;
            @(negedge clk);
            chk("rst_w_ready", 64'(axi_wready), 64'd1);
            @(posedge clk); #1;
            model[16 + k] = wbuf[k];
        end
        axi_wdata = wbuf[2];
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        check_reset_vals("midburst");
        axi_wvalid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
        @(negedge clk);
        chk("rst_ready_low", {axi_awready, axi_arready}, 2'b00);
        @(posedge clk); #1;
        @(negedge clk);
        chk("rst_ready_high", {axi_awready, axi_arready}, 2'b11);
        read_burst(32'h40, 3, 3'd2, 2'b01, 0);
        for (int k = 0; k < 2; k++) wbuf[k] = $urandom;
        write_burst(32'h40, 1, 3'd2, 2'b01, -1, 1'b0);
        read_burst(32'h40, 3, 3'd2, 2'b01, 2);

        repeat (5) @(posedge clk);
        #1;
        chk("bq_empty", 64'(bq.size()), 64'd0);
        chk("rq_empty", 64'(rq.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
